// File: rtl/sd_sched_pkg.sv
// Shared types and widths for the SD sector-read scheduler.
package sd_sched_pkg;
  localparam int SEC_ADDR_W = 32;
  localparam int CNT_W      = 8;
  localparam int GRANT_W    = 2;
  localparam int REM_W      = CNT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} sched_state_e;

  // A zero count means a full 256-sector job.
  function automatic logic [REM_W-1:0] count_to_rem(input logic [CNT_W-1:0] c);
    return (c == '0) ? (REM_W'(1) << CNT_W) : {1'b0, c};
  endfunction
endpackage

// File: rtl/sd_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, with wrap.
module sd_rr_arbiter
  import sd_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [GRANT_W-1:0] idx_o
);
  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = GRANT_W'(j);
      end
    end
  end
endmodule

// File: rtl/sd_read_scheduler.sv
// Round-robin sharing of the SD sector-read core between NUM_REQ requesters.
// Optional per-sector watchdog compiled in with SD_SCHED_TIMEOUT_EN.
module sd_read_scheduler
  import sd_sched_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          core_init_done,
  input  logic                          soft_abort,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*SEC_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*CNT_W-1:0]      req_count,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic [7:0]                    rd_data,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic                          busy,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          core_rd_start,
  output logic [SEC_ADDR_W-1:0]         core_rd_addr,
  input  logic                          core_rd_done,
  input  logic                          core_rd_valid,
  input  logic [7:0]                    core_rd_data,
  output logic                          core_rst
);
  sched_state_e          state_q, state_d;
  logic [SEC_ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [GRANT_W-1:0]    owner_q, owner_d, ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d, done_q, done_d, rv_q, rv_d, gnt_oh;
  logic [GRANT_W-1:0]    gnt_idx;
  logic                  err_q, err_d, busy_q, busy_d, start_q, start_d, rst_q, rst_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  grant_ok, byte_ok, abort, expire, enter_done;

  sd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx)
  );

  assign grant_ok   = core_init_done && !soft_abort && (|req_valid);
  assign byte_ok    = (state_q == ST_WAIT) && core_rd_valid;
  assign abort      = soft_abort && (state_q == ST_START || state_q == ST_WAIT);
  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

`ifdef SD_SCHED_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d;
  assign expire = (state_q == ST_WAIT) && (wdog_q == TIMEOUT_CYCLES - 24'd1);
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_START)     wdog_d = '0;
    else if (state_q == ST_WAIT) wdog_d = wdog_q + 24'd1;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) wdog_q <= '0;
    else          wdog_q <= wdog_d;
`else
  logic [23:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rv_q    <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (grant_ok) begin
        state_d = ST_START;
        owner_d = gnt_idx;
        addr_d  = req_addr[SEC_ADDR_W*int'(gnt_idx) +: SEC_ADDR_W];
        rem_d   = count_to_rem(req_count[CNT_W*int'(gnt_idx) +: CNT_W]);
      end
      ST_START: state_d = soft_abort ? ST_DONE : ST_WAIT;
      // Abort outranks a simultaneous sector completion.
      ST_WAIT: begin
        if (soft_abort) state_d = ST_DONE;
        else if (core_rd_done) begin
          if (rem_q == REM_W'(1)) state_d = ST_DONE;
          else begin
            state_d = ST_START;
            addr_d  = addr_q + SEC_ADDR_W'(1);
            rem_d   = rem_q - REM_W'(1);
          end
        end else if (expire) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (owner_q == GRANT_W'(NUM_REQ-1)) ? '0 : owner_q + GRANT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered-output next values; every pulse lasts exactly one cycle.
  always_comb begin
    ready_d = (state_q == ST_IDLE && grant_ok) ? gnt_oh : '0;
    start_d = (state_q == ST_START) && !soft_abort;
    rst_d   = abort || (expire && !core_rd_done);
    err_d   = enter_done && !(core_rd_done && !soft_abort);
    busy_d  = (state_d == ST_START) || (state_d == ST_WAIT);
    rdata_d = byte_ok ? core_rd_data : rdata_q;
    done_d  = '0;
    rv_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_d[i] = enter_done && (owner_q == GRANT_W'(i));
      rv_d[i]   = byte_ok && (owner_q == GRANT_W'(i));
    end
  end

  assign req_ready     = ready_q;
  assign req_done      = done_q;
  assign req_err       = err_q;
  assign rd_data       = rdata_q;
  assign rd_valid      = rv_q;
  assign busy          = busy_q;
  assign grant_id      = owner_q;
  assign core_rd_start = start_q;
  assign core_rd_addr  = addr_q;
  assign core_rst      = rst_q;
endmodule

// File: tb/tb_sd_read_scheduler.sv
// Directed self-checking bench for sd_read_scheduler (NUM_REQ=2).
module tb_sd_read_scheduler;
  localparam int NR = 2;

  logic PCLK = 1'b0;
  logic PRESETn, core_init_done, soft_abort;
  logic [NR-1:0] req_valid;
  logic [NR*32-1:0] req_addr;
  logic [NR*8-1:0] req_count;
  logic [NR-1:0] req_ready, req_done, rd_valid;
  logic req_err, busy, core_rd_start, core_rst;
  logic [7:0] rd_data, core_rd_data;
  logic [1:0] grant_id;
  logic [31:0] core_rd_addr;
  logic core_rd_done, core_rd_valid;

  // core model (auto) plus manual overrides from the tests
  logic core_auto = 1'b0;
  int resp_delay = 2;
  int cd = 0;
  logic m_done = 1'b0, m_valid = 1'b0, t_done = 1'b0, t_valid = 1'b0;
  logic [7:0] m_data = 8'h00, t_data = 8'h00;
  assign core_rd_done  = m_done | t_done;
  assign core_rd_valid = m_valid | t_valid;
  assign core_rd_data  = t_valid ? t_data : m_data;

  int tests = 0, fails = 0;

  // monitor bookkeeping
  int cyc = 0, n_start = 0, n_rst = 0, n_misroute = 0, last_done_cyc = 0;
  int n_rv [NR];
  logic [31:0] start_addr_q[$];
  int start_cyc_q[$], cd_cyc_q[$];
  logic [1:0] grant_q[$];

  sd_read_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(24'd100)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .core_init_done(core_init_done), .soft_abort(soft_abort),
    .req_valid(req_valid), .req_addr(req_addr), .req_count(req_count),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .grant_id(grant_id),
    .core_rd_start(core_rd_start), .core_rd_addr(core_rd_addr),
    .core_rd_done(core_rd_done), .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
    .core_rst(core_rst)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    #1;
    m_done  = 1'b0;
    if (!core_auto) cd = 0;
    else if (core_rd_start) cd = resp_delay;
    else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) m_done = 1'b1;
    end
    m_valid = core_auto && (m_done || cd == 1);
    m_data  = core_rd_addr[7:0] ^ 8'h5A;
  end

  initial for (int i = 0; i < NR; i++) n_rv[i] = 0;

  always @(negedge PCLK) begin
    cyc <= cyc + 1;
    if (core_rd_start) begin
      n_start <= n_start + 1;
      start_addr_q.push_back(core_rd_addr);
      start_cyc_q.push_back(cyc);
    end
    if (core_rd_done) cd_cyc_q.push_back(cyc);
    if (core_rst) n_rst <= n_rst + 1;
    if (|req_done) last_done_cyc <= cyc;
    if (|req_ready) grant_q.push_back(grant_id);
    for (int i = 0; i < NR; i++) if (rd_valid[i]) n_rv[i] <= n_rv[i] + 1;
    if (rd_valid != '0 && rd_valid != (NR'(1) << grant_id)) n_misroute <= n_misroute + 1;
  end

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic pulse_reset();
    PRESETn = 1'b0; tick(); tick(); PRESETn = 1'b1; tick();
  endtask

  task automatic run_job(input int r, input logic [31:0] a, input logic [7:0] c, input int maxc,
                         output bit ok);
    req_addr[32*r +: 32] = a;
    req_count[8*r +: 8]  = c;
    req_valid[r] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); if (req_ready[r]) ok = 1; end
    req_valid[r] = 1'b0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < maxc && !ok; i++) begin tick(); if (req_done[r]) ok = 1; end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    tests++;
    if ({req_ready, req_done, req_err, rd_data, rd_valid, busy, grant_id, core_rd_start, core_rd_addr, core_rst} !== '0) begin
      fails++; $display("FAIL reset_outputs: got busy=%b addr=%h ready=%b start=%b, want all 0",
                        busy, core_rd_addr, req_ready, core_rd_start);
    end
    PRESETn = 1'b1; tick();
  endtask

  task automatic test_init_gate();
    bit ok;
    int gb;
    gb = grant_q.size();
    core_auto = 1'b1; resp_delay = 3;
    req_addr[31:0] = 32'h55; req_count[7:0] = 8'd1; req_valid = 2'b01;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (grant_q.size() != gb || busy !== 1'b0) begin
      fails++; $display("FAIL init_gate_block: grants=%0d busy=%b, want 0 0", grant_q.size() - gb, busy);
    end
    core_init_done = 1'b1;
    tick();
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("FAIL init_ready: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
    tests++;
    if (core_rd_start !== 1'b1 || core_rd_addr !== 32'h55) begin
      fails++; $display("FAIL init_start: got start=%b addr=%h want 1 00000055", core_rd_start, core_rd_addr);
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); if (|req_done) ok = 1; end
    tests++;
    if (!ok || req_done !== 2'b01 || req_err !== 1'b0) begin
      fails++; $display("FAIL init_done: got done=%b err=%b ok=%0d want 01 0", req_done, req_err, ok);
    end
    tick(); tick();
  endtask

  task automatic test_multi_sector();
    bit ok;
    int sb, cb;
    sb = start_addr_q.size(); cb = cd_cyc_q.size();
    resp_delay = 10;
    run_job(0, 32'h100, 8'd3, 200, ok);
    tests++;
    if (!ok || req_err !== 1'b0) begin fails++; $display("FAIL multi_done: ok=%0d err=%b want 1 0", ok, req_err); end
    tests++;
    if (rd_valid !== 2'b01 || rd_data !== 8'h58) begin
      fails++; $display("FAIL multi_last_byte: got rv=%b data=%h want 01 58", rd_valid, rd_data);
    end
    tick();
    tests++;
    if (start_addr_q.size() - sb != 3 || start_addr_q[sb] !== 32'h100 || start_addr_q[sb+1] !== 32'h101 ||
        start_addr_q[sb+2] !== 32'h102) begin
      fails++; $display("FAIL multi_addrs: got %0d starts, want 3 at 100,101,102", start_addr_q.size() - sb);
    end else begin
      tests++;
      if (start_cyc_q[sb+1] - cd_cyc_q[cb] != 2) begin
        fails++; $display("FAIL multi_latency: got %0d want 2", start_cyc_q[sb+1] - cd_cyc_q[cb]);
      end
      tests++;
      if (last_done_cyc - cd_cyc_q[cb+2] != 1) begin
        fails++; $display("FAIL multi_done_lat: got %0d want 1", last_done_cyc - cd_cyc_q[cb+2]);
      end
    end
  endtask

  task automatic test_round_robin();
    int gb, mb, rv0, rv1;
    pulse_reset();
    gb = grant_q.size(); mb = n_misroute; rv0 = n_rv[0]; rv1 = n_rv[1];
    resp_delay = 2;
    req_addr = {32'h20, 32'h10}; req_count = {8'd1, 8'd1}; req_valid = 2'b11;
    for (int i = 0; i < 200 && (grant_q.size() - gb) < 4; i++) begin
      tick();
      for (int k = 0; k < NR; k++) begin
        if (req_ready[k]) begin
          tests++;
          if (grant_id !== 2'(k)) begin fails++; $display("FAIL rr_grant_id: got %0d want %0d", grant_id, k); end
          req_valid[k] = 1'b0;
        end
        if (req_done[k]) req_valid[k] = 1'b1;
      end
    end
    req_valid = 2'b00;
    for (int i = 0; i < 30; i++) tick();
    tests++;
    if (grant_q.size() - gb < 4) begin
      fails++; $display("FAIL rr_count: got %0d grants want 4", grant_q.size() - gb);
    end else if (grant_q[gb] !== 2'd0 || grant_q[gb+1] !== 2'd1 || grant_q[gb+2] !== 2'd0 || grant_q[gb+3] !== 2'd1) begin
      fails++; $display("FAIL rr_order: got %0d,%0d,%0d,%0d want 0,1,0,1",
                        grant_q[gb], grant_q[gb+1], grant_q[gb+2], grant_q[gb+3]);
    end
    tests++;
    if (n_misroute != mb || n_rv[0] <= rv0 || n_rv[1] <= rv1) begin
      fails++; $display("FAIL rr_routing: misroutes=%0d bytes0=%0d bytes1=%0d want 0 >0 >0",
                        n_misroute - mb, n_rv[0] - rv0, n_rv[1] - rv1);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    int sb;
    sb = start_addr_q.size();
    run_job(1, 32'hFFFF_FFFF, 8'd2, 100, ok);
    tests++;
    if (!ok || req_done !== 2'b10) begin fails++; $display("FAIL wrap_done: ok=%0d done=%b want 1 10", ok, req_done); end
    tick();
    tests++;
    if (start_addr_q.size() - sb != 2 || start_addr_q[sb] !== 32'hFFFF_FFFF || start_addr_q[sb+1] !== 32'h0) begin
      fails++; $display("FAIL wrap_addr: got %0d starts, want FFFFFFFF then 00000000", start_addr_q.size() - sb);
    end
  endtask

  task automatic test_count_256();
    bit ok;
    int sb;
    sb = start_addr_q.size();
    resp_delay = 1;
    run_job(0, 32'h1000, 8'd0, 2000, ok);
    tick();
    tests++;
    if (!ok || start_addr_q.size() - sb != 256) begin
      fails++; $display("FAIL count256: ok=%0d got %0d starts want 256", ok, start_addr_q.size() - sb);
    end else begin
      tests++;
      if (start_addr_q[sb+255] !== 32'h10FF) begin
        fails++; $display("FAIL count256_last: got %h want 000010FF", start_addr_q[sb+255]);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int bad;
    core_auto = 1'b0; tick();
    req_addr[31:0] = 32'h200; req_count[7:0] = 8'd4; req_valid = 2'b01;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (req_ready[0]) ok = 1; end
    req_valid = 2'b00;
    tick();
    tests++;
    if (!ok || core_rd_start !== 1'b1 || core_rd_addr !== 32'h200) begin
      fails++; $display("FAIL abort_start: ok=%0d start=%b addr=%h want 1 1 00000200", ok, core_rd_start, core_rd_addr);
    end
    tick();
    t_valid = 1'b1; t_data = 8'h11;
    tick();
    tests++;
    if (rd_valid !== 2'b01 || rd_data !== 8'h11) begin
      fails++; $display("FAIL abort_byte_fwd: got rv=%b data=%h want 01 11", rd_valid, rd_data);
    end
    t_done = 1'b1; soft_abort = 1'b1; t_data = 8'h22;
    tick();
    tests++;
    if (core_rst !== 1'b1 || req_done !== 2'b01 || req_err !== 1'b1) begin
      fails++; $display("FAIL abort_pulse: got rst=%b done=%b err=%b want 1 01 1", core_rst, req_done, req_err);
    end
    t_done = 1'b0; soft_abort = 1'b0; t_data = 8'h33;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      t_done = (i == 4);
      tick();
      if (rd_valid !== 2'b00 || core_rd_start !== 1'b0 || core_rst !== 1'b0 || busy !== 1'b0 || req_done !== 2'b00) bad++;
    end
    t_done = 1'b0; t_valid = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL abort_after: got %0d bad cycles want 0", bad); end
    // abort in IDLE only holds off grants
    soft_abort = 1'b1; req_count[7:0] = 8'd1; req_valid = 2'b01;
    bad = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (req_ready !== 2'b00) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL abort_idle_block: got %0d ready cycles want 0", bad); end
    soft_abort = 1'b0;
    tick();
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("FAIL abort_idle_release: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick(); tick();
    t_done = 1'b1; tick(); t_done = 1'b0;
    tests++;
    if (req_done !== 2'b01 || req_err !== 1'b0) begin
      fails++; $display("FAIL abort_idle_job: got done=%b err=%b want 01 0", req_done, req_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int bad;
    core_auto = 1'b1; resp_delay = 10;
    req_addr[63:32] = 32'h300; req_count[15:8] = 8'd4; req_valid = 2'b10;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (req_ready[1]) ok = 1; end
    req_valid = 2'b00;
    tick(); tick();
    PRESETn = 1'b0; #1;
    tests++;
    if (!ok || {busy, core_rd_addr, grant_id, req_ready, rd_valid, req_done, core_rd_start} !== '0) begin
      fails++; $display("FAIL midreset_outputs: ok=%0d busy=%b addr=%h gid=%0d want 1 0 0 0", ok, busy, core_rd_addr, grant_id);
    end
    core_auto = 1'b0;
    tick(); PRESETn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (req_done !== 2'b00 || busy !== 1'b0) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_timeout();
    bit ok;
    int bad;
    core_auto = 1'b0;
    req_addr[31:0] = 32'h400; req_count[7:0] = 8'd1; req_valid = 2'b01;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (req_ready[0]) ok = 1; end
    req_valid = 2'b00;
    tick();
    bad = 0;
    for (int i = 2; i <= 100; i++) begin tick(); if (core_rst !== 1'b0 || req_done !== 2'b00) bad++; end
    tests++;
    if (!ok || bad != 0) begin fails++; $display("FAIL timeout_quiet: ok=%0d bad=%0d want 1 0", ok, bad); end
`ifdef SD_SCHED_TIMEOUT_EN
    tick();
    tests++;
    if (core_rst !== 1'b1 || req_done !== 2'b01 || req_err !== 1'b1) begin
      fails++; $display("FAIL timeout_expire: got rst=%b done=%b err=%b want 1 01 1", core_rst, req_done, req_err);
    end
    tick(); tick();
    req_valid = 2'b01;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (req_ready[0]) ok = 1; end
    req_valid = 2'b00;
    tick();
    for (int i = 2; i <= 100; i++) tick();
`else
    bad = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (core_rst !== 1'b0 || busy !== 1'b1) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad); end
`endif
    t_done = 1'b1; tick(); t_done = 1'b0;
    tests++;
    if (!ok || req_done !== 2'b01 || req_err !== 1'b0 || core_rst !== 1'b0) begin
      fails++; $display("FAIL timeout_late_done: ok=%0d done=%b err=%b rst=%b want 1 01 0 0", ok, req_done, req_err, core_rst);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    PRESETn = 1'b0; core_init_done = 1'b0; soft_abort = 1'b0;
    req_valid = '0; req_addr = '0; req_count = '0;
    test_reset();
    test_init_gate();
    test_multi_sector();
    test_round_robin();
    test_addr_wrap();
    test_count_256();
    test_abort();
    test_reset_mid_job();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_read_scheduler.md
Name: sd_read_scheduler

Overview:
- Shares the SD-card sector-read core between NUM_REQ requesters, for example the CPU register path and the ISP/frame-buffer DMA.
- Each request is a start sector plus a sector count. The block arbitrates round-robin, issues one core read per sector, routes the returned bytes to the owning requester, and reports completion or error.
- Sits between the APB SD-card control registers / DMA masters and the SD read core.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 24'd5000000, per-sector watchdog limit. Used only when the optional feature is compiled in.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- core_init_done  in  1  SD core initialised; no grants while low.
- soft_abort  in  1  level; abort current job (driven from the sdcard_rd_reset register bit).
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_addr  in  NUM_REQ*32  start sector, requester i at bits [32i+31:32i].
- req_count  in  NUM_REQ*8  sector count, requester i at bits [8i+7:8i]; 0 means 256.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the winner.
- req_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_err  out  1  valid only with req_done; 1 = aborted or timed out.
- rd_data  out  8  registered byte, broadcast to all requesters.
- rd_valid  out  NUM_REQ  registered, one-hot to the owner.
- busy  out  1  job in progress.
- grant_id  out  2  current owner index.
- core_rd_start  out  1  one-cycle sector-read start.
- core_rd_addr  out  32  sector address, stable from core_rd_start until core_rd_done.
- core_rd_done  in  1  sector complete pulse.
- core_rd_valid  in  1  byte strobe.
- core_rd_data  in  8  byte.
- core_rst  out  1  one-cycle reset pulse to the core.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE: when core_init_done=1, soft_abort=0 and any req_valid=1:
  - pick the winner round-robin, searching from the pointer upward with wrap;
  - latch addr and count (0 becomes 256);
  - pulse req_ready[winner] for exactly 1 cycle, set grant_id, busy=1;
  - go to START.
- Requester protocol: a requester holds req_valid/addr/count stable until req_ready, and must not reassert req_valid until it has seen req_done.
- START: core_rd_start=1 for one cycle with core_rd_addr=cur_addr, then go to WAIT.
- WAIT: on core_rd_done:
  - if remaining==1, go to DONE with err=0;
  - otherwise cur_addr+1 (mod 2^32, wraps 0xFFFFFFFF to 0), remaining-1, go to START.
  - Latency: core_rd_done to the next core_rd_start is exactly 2 cycles.
- DONE: req_done[owner]=1 and req_err=err for one cycle; pointer = owner+1 mod NUM_REQ; busy=0; go to IDLE. The next grant is possible one cycle later.
- Data routing:
  - core_rd_valid in WAIT (including the core_rd_done cycle) gives rd_valid[owner]=1 and rd_data=core_rd_data on the next cycle.
  - Bytes arriving in IDLE/START/DONE are dropped.
  - The last byte of a job is never later than req_done.
- soft_abort=1 while in START or WAIT:
  - next state is DONE with err=1;
  - core_rst pulses 1 cycle;
  - no further core_rd_start.
  - soft_abort in IDLE blocks grants only. Abort takes priority over a simultaneous core_rd_done.
- An unexpected core_rd_done outside WAIT is ignored.
- PRESETn low mid-job: immediate return to IDLE, all outputs 0, no req_done emitted.
- Round-robin fairness: with all NUM_REQ requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1.

Optional Feature:
- Macro SD_SCHED_TIMEOUT_EN.
- Defined:
  - a 24-bit watchdog clears on entry to WAIT and counts each WAIT cycle;
  - on reaching TIMEOUT_CYCLES without core_rd_done, core_rst pulses 1 cycle, then DONE with err=1;
  - core_rd_done in the same cycle as expiry wins, so no error is reported.
- Not defined: no counter exists; WAIT waits indefinitely; core_rst is driven only by soft_abort.

Decomposition:
- Package sd_sched_pkg:
  - FSM state enum;
  - SEC_ADDR_W=32, CNT_W=8, GRANT_W=2;
  - encoding of count 0 as 256.
- Sub-module sd_rr_arbiter: inputs req vector and pointer; outputs one-hot grant and index (combinational). The FSM registers the result.

Test Plan:
- core_init_done=0, req_valid=01 → no req_ready; raise init_done → req_ready[0] next cycle, core_rd_start one cycle later with addr latched.
- Req0 addr=0x100, count=3; each core_rd_done after 10 cycles → core_rd_addr 0x100, 0x101, 0x102; req_done[0]=1, req_err=0 one cycle after the third done.
- Req0 and req1 continuously valid, count=1 each → grants alternate 0,1,0,1; grant_id matches; each job's rd_valid goes only to its owner.
- Req1 addr=0xFFFFFFFF, count=2 → second core_rd_addr is 0x00000000; count=0 → exactly 256 core_rd_start pulses.
- soft_abort during WAIT of a count=4 job, same cycle as core_rd_done → core_rst pulse, req_done with req_err=1, no further core_rd_start; bytes arriving after the abort are not forwarded.
- SD_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, core never completes → core_rst at WAIT cycle 100, then req_err=1; repeat with done at cycle 100 → req_err=0.
